// File: rtl/seq_divider.sv
// Iterative restoring unsigned divider: one quotient bit per cycle, MSB first,
// with a start/busy/done handshake. Q/R/div_by_zero only change on completion.
module seq_divider #(
  parameter int DW = 16,
  parameter int VW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [DW-1:0] A,
  input  logic [VW-1:0] B,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] Q,
  output logic [VW-1:0] R,
  output logic          div_by_zero
);

  localparam int CW = $clog2(DW + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(DW);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] dvd_q, dvd_d;
  logic [VW-1:0] dvs_q, dvs_d;
  logic [VW-1:0] rem_q, rem_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] quo_q, quo_d;
  logic [DW-1:0] q_q, q_d;
  logic [VW-1:0] r_q, r_d;
  logic          dbz_q, dbz_d;

  // The shifted partial remainder needs VW+1 bits before the compare; after a
  // restoring subtract it is always < divisor, so only VW bits are stored.
  logic [VW:0]   rem_sh, rem_nx;
  logic          q_bit;
  logic [DW-1:0] quo_nx;

  always_comb begin
    rem_sh = {rem_q, dvd_q[DW-1]};
    q_bit  = (rem_sh >= {1'b0, dvs_q});
    rem_nx = q_bit ? (rem_sh - {1'b0, dvs_q}) : rem_sh;
    quo_nx = {quo_q[DW-2:0], q_bit};
  end

  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    q_d     = q_q;
    r_d     = r_q;
    dbz_d   = dbz_q;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          dvd_d = A;
          dvs_d = B;
          rem_d = '0;
          cnt_d = CNT_INIT;
          quo_d = '0;
          if (B == '0) begin
            state_d = DONE;
            q_d     = '1;
            r_d     = A[VW-1:0];
            dbz_d   = 1'b1;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        dvd_d = dvd_q << 1;
        rem_d = rem_nx[VW-1:0];
        quo_d = quo_nx;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = DONE;
          q_d     = quo_nx;
          r_d     = rem_nx[VW-1:0];
          dbz_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      quo_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy        = (state_q == RUN);
  assign done        = (state_q == DONE);
  assign Q           = q_q;
  assign R           = r_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: a cycle-level reference model built from start
// acceptance times and plain / and %, plus directed literal checks.
module tb_seq_divider;
  localparam int DW = 16;
  localparam int VW = 8;

  logic          clk = 1'b0;
  logic          reset, start;
  logic [DW-1:0] A;
  logic [VW-1:0] B;
  logic          busy, done, div_by_zero;
  logic [DW-1:0] Q;
  logic [VW-1:0] R;

  seq_divider #(.DW(DW), .VW(VW)) dut (
    .clk(clk), .reset(reset), .start(start), .A(A), .B(B),
    .busy(busy), .done(done), .Q(Q), .R(R), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  int vecs = 0;
  int errs = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference model: an op accepted in cycle s is busy in s+1..s+DW and done
  // in s+DW+1 (or done in s+1 with no busy when B==0).
  int            cyc = 0;
  bit            chk_en = 0;
  bit            pend = 0, pz = 0;
  int            ps = 0;
  logic [DW-1:0] pq, hq;
  logic [VW-1:0] pr, hr;
  logic          hz;

  function automatic bit m_busy(input int c);
    return pend && !pz && c >= ps + 1 && c <= ps + DW;
  endfunction

  function automatic bit m_done(input int c);
    return pend && c == ps + (pz ? 1 : DW + 1);
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      pend = 0;
      hq = '0; hr = '0; hz = 1'b0;
    end else if (start && !m_busy(cyc)) begin
      pend = 1;
      ps   = cyc;
      pz   = (B == 0);
      if (B == 0) begin
        pq = '1;
        pr = A[VW-1:0];
      end else begin
        pq = DW'(int'(A) / int'(B));
        pr = VW'(int'(A) % int'(B));
      end
    end
    cyc++;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      if (m_done(cyc)) begin
        hq = pq; hr = pr; hz = pz;
      end
      chk("busy", busy, m_busy(cyc));
      chk("done", done, m_done(cyc));
      chk("Q", Q, hq);
      chk("R", R, hr);
      chk("div_by_zero", div_by_zero, hz);
    end
  end

  // Waits for done at negedge; lat counts cycles from the start cycle.
  task automatic wait_done(output int lat);
    bit got;
    got = 0;
    lat = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        got = 1;
        lat = i + 1;
        break;
      end
    end
    if (!got) begin
      vecs++;
      errs++;
      $display("FAIL done_timeout: got no done expected done within 40 cycles");
    end
  endtask

  task automatic pulse_start(input logic [DW-1:0] a, input logic [VW-1:0] b);
    @(posedge clk); #1;
    start = 1'b1; A = a; B = b;
    @(posedge clk); #1;
    start = 1'b0;
    A = DW'($urandom);
    B = VW'($urandom);
  endtask

  task automatic run_op(input logic [DW-1:0] a, input logic [VW-1:0] b, output int lat);
    pulse_start(a, b);
    wait_done(lat);
  endtask

  int lat;
  int ra, rb;

  initial begin
    reset = 1'b1; start = 1'b0; A = '0; B = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk_en = 1;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_Q", Q, 0);
    chk("rst_R", R, 0);
    chk("rst_dbz", div_by_zero, 0);

    run_op(16'd1000, 8'd7, lat);
    chk("lat_1000_7", lat, 17);
    chk("Q_1000_7", Q, 142);
    chk("R_1000_7", R, 6);
    chk("dbz_1000_7", div_by_zero, 0);

    run_op(16'hFFFF, 8'd1, lat);
    chk("Q_ffff_1", Q, 16'hFFFF);
    chk("R_ffff_1", R, 0);
    run_op(16'hFFFF, 8'hFF, lat);
    chk("Q_ffff_ff", Q, 257);
    chk("R_ffff_ff", R, 0);

    run_op(16'd12, 8'd200, lat);
    chk("Q_12_200", Q, 0);
    chk("R_12_200", R, 12);
    run_op(16'd5, 8'd0, lat);
    chk("lat_div0", lat, 1);
    chk("Q_div0", Q, 16'hFFFF);
    chk("R_div0", R, 5);
    chk("dbz_div0", div_by_zero, 1);

    // start while busy must be ignored
    @(posedge clk); #1;
    start = 1'b1; A = 16'd100; B = 8'd9;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1 start = 1'b1; A = 16'd1; B = 8'd1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(lat);
    chk("Q_100_9", Q, 11);
    chk("R_100_9", R, 1);
    chk("dbz_100_9", div_by_zero, 0);
    // back-to-back: start held in the done cycle
    start = 1'b1; A = 16'd50; B = 8'd5;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(lat);
    chk("lat_b2b", lat, 17);
    chk("Q_50_5", Q, 10);
    chk("R_50_5", R, 0);

    // reset mid-operation
    pulse_start(16'd40000, 8'd3);
    repeat (7) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_Q", Q, 0);
    chk("abort_R", R, 0);
    chk("abort_dbz", div_by_zero, 0);
    repeat (20) @(negedge clk);
    run_op(16'd40000, 8'd3, lat);
    chk("lat_40000_3", lat, 17);
    chk("Q_40000_3", Q, 13333);
    chk("R_40000_3", R, 1);

    for (int i = 0; i < 500; i++) begin
      ra = $urandom_range(1, 255);
      rb = $urandom_range(1, 255);
      run_op(DW'(ra * rb), VW'(rb), lat);
      chk("prod_Q", Q, ra);
      chk("prod_R", R, 0);
    end

    for (int i = 0; i < 500; i++) begin
      ra = int'($urandom_range(0, 65535));
      rb = int'($urandom_range(0, 255));
      run_op(DW'(ra), VW'(rb), lat);
      if (rb != 0) begin
        chk("inv_eq", int'(Q) * rb + int'(R), ra);
        chk("inv_rlt", (int'(R) < rb), 1);
      end else begin
        chk("rnd_div0_Q", Q, 16'hFFFF);
        chk("rnd_div0_dbz", div_by_zero, 1);
      end
    end

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
